// File: rtl/ysyx_040066_csr_pkg.sv
// ysyx_040066_csr_pkg: CSR addresses, mstatus fields, interrupt codes and reset constants
package ysyx_040066_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam int MS_MIE    = 3;
    localparam int MS_MPIE   = 7;
    localparam int MS_MPP_LO = 11;

    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_MEI = 5'd11;

    // Truncating to 32 bits leaves exactly the RV32 reset value 0x1800
    localparam logic [63:0] MSTATUS_RST = 64'h0000_000A_0000_1800;

    typedef enum logic [1:0] {EV_NONE, EV_EXC, EV_IRQ, EV_MRET} csr_event_e;

    function automatic logic csr_impl(input logic [11:0] a);
        return a inside {CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
                         CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MHARTID};
    endfunction

    function automatic logic csr_writable(input logic [11:0] a);
        return csr_impl(a) && a != CSR_MIP && a != CSR_MHARTID;
    endfunction

endpackage

// File: rtl/ysyx_040066_csr_cnt.sv
// ysyx_040066_csr_cnt: wrapping counter with increment enable; a write overrides the increment
module ysyx_040066_csr_cnt #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         we,
    input  logic [W-1:0] wd,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = we ? wd : cnt_q + W'(inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/ysyx_040066_mcsr.sv
// ysyx_040066_mcsr: machine-mode CSR file with trap entry, mret and interrupt arbitration
module ysyx_040066_mcsr
    import ysyx_040066_csr_pkg::*;
#(
    parameter int          XLEN        = 64,
    parameter int          HARTID      = 0,
    parameter int          VECTORED_EN = 1,
    parameter logic [63:0] MTVEC_RST   = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_rd_addr,
    output logic [XLEN-1:0] csr_rd_data,
    output logic            csr_rd_err,
    input  logic            csr_wr_en,
    input  logic [11:0]     csr_wr_addr,
    input  logic [XLEN-1:0] csr_wr_data,
    output logic            csr_wr_err,
    input  logic            exc_valid,
    input  logic [XLEN-2:0] exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            irq_msip,
    input  logic            irq_mtip,
    input  logic            irq_meip,
    input  logic [XLEN-1:0] irq_pc,
    input  logic            mret,
    input  logic            instret,
    output logic            jmp,
    output logic [XLEN-1:0] nxtpc,
    output logic            irq_take,
    output logic [XLEN-1:0] mstatus_o,
    output logic [XLEN-1:0] mie_o
);

    localparam logic [XLEN-1:0] LOW2 = XLEN'(3);

    logic [XLEN-1:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d, mcycle, minstret;
    logic [XLEN-1:0] mip, pending, wr_masked, rd_raw, trap_pc, tvec_base;
    logic [4:0]      irq_code;
    logic            irq_req, wr_ok;
    csr_event_e      ev;

    always_comb begin
        mip            = '0;
        mip[IRQ_MSI]   = irq_msip;
        mip[IRQ_MTI]   = irq_mtip;
        mip[IRQ_MEI]   = irq_meip;
        pending        = mip & mie_q;
        irq_code       = pending[IRQ_MEI] ? IRQ_MEI : pending[IRQ_MSI] ? IRQ_MSI : IRQ_MTI;
        irq_req        = mstatus_q[MS_MIE] & |pending & ~exc_valid & ~mret;
        ev             = exc_valid ? EV_EXC : irq_req ? EV_IRQ : mret ? EV_MRET : EV_NONE;
        wr_ok          = csr_wr_en && ev == EV_NONE;
        wr_masked      = (csr_wr_addr == CSR_MEPC || (csr_wr_addr == CSR_MTVEC && csr_wr_data[1]))
                         ? csr_wr_data & ~LOW2 : csr_wr_data;
        trap_pc        = (ev == EV_EXC ? exc_pc : irq_pc) & ~LOW2;
        tvec_base      = mtvec_q & ~LOW2;
    end

    always_comb begin
        case (csr_rd_addr)
            CSR_MSTATUS:  rd_raw = mstatus_q;
            CSR_MIE:      rd_raw = mie_q;
            CSR_MTVEC:    rd_raw = mtvec_q;
            CSR_MSCRATCH: rd_raw = mscratch_q;
            CSR_MEPC:     rd_raw = mepc_q;
            CSR_MCAUSE:   rd_raw = mcause_q;
            CSR_MTVAL:    rd_raw = mtval_q;
            CSR_MIP:      rd_raw = mip;
            CSR_MCYCLE:   rd_raw = mcycle;
            CSR_MINSTRET: rd_raw = minstret;
            CSR_MHARTID:  rd_raw = XLEN'(HARTID);
            default:      rd_raw = '0;
        endcase
        csr_rd_data = (csr_wr_en && csr_wr_addr == csr_rd_addr && csr_writable(csr_wr_addr))
                      ? wr_masked : rd_raw;
        csr_rd_err  = !csr_impl(csr_rd_addr);
        csr_wr_err  = csr_wr_en && !csr_impl(csr_wr_addr);
    end

    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        case (ev)
            EV_EXC, EV_IRQ: begin
                mepc_d                    = trap_pc;
                mcause_d                  = ev == EV_EXC ? {1'b0, exc_cause}
                                                         : {1'b1, (XLEN-1)'(irq_code)};
                mtval_d                   = ev == EV_EXC ? exc_tval : '0;
                mstatus_d[MS_MPIE]        = mstatus_q[MS_MIE];
                mstatus_d[MS_MIE]         = 1'b0;
                mstatus_d[MS_MPP_LO +: 2] = 2'b11;
            end
            EV_MRET: begin
                mstatus_d[MS_MIE]         = mstatus_q[MS_MPIE];
                mstatus_d[MS_MPIE]        = 1'b1;
                mstatus_d[MS_MPP_LO +: 2] = 2'b00;
            end
            default: begin
                if (wr_ok) begin
                    case (csr_wr_addr)
                        CSR_MSTATUS:  mstatus_d  = wr_masked;
                        CSR_MIE:      mie_d      = wr_masked;
                        CSR_MTVEC:    mtvec_d    = wr_masked;
                        CSR_MSCRATCH: mscratch_d = wr_masked;
                        CSR_MEPC:     mepc_d     = wr_masked;
                        CSR_MCAUSE:   mcause_d   = wr_masked;
                        CSR_MTVAL:    mtval_d    = wr_masked;
                        default:      ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q  <= MSTATUS_RST[XLEN-1:0];
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST[XLEN-1:0];
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    ysyx_040066_csr_cnt #(.W(XLEN)) u_mcycle (
        .clk (clk),
        .rst (rst),
        .inc (1'b1),
        .we  (wr_ok && csr_wr_addr == CSR_MCYCLE),
        .wd  (wr_masked),
        .q   (mcycle)
    );

    ysyx_040066_csr_cnt #(.W(XLEN)) u_minstret (
        .clk (clk),
        .rst (rst),
        .inc (instret),
        .we  (wr_ok && csr_wr_addr == CSR_MINSTRET),
        .wd  (wr_masked),
        .q   (minstret)
    );

    // Redirects are masked while reset is held so a stale trap never escapes
    always_comb begin
        jmp       = ~rst && ev != EV_NONE;
        irq_take  = ~rst && irq_req;
        nxtpc     = ev == EV_MRET ? mepc_q
                  : (ev == EV_IRQ && VECTORED_EN != 0 && mtvec_q[1:0] == 2'b01)
                    ? tvec_base + XLEN'({irq_code, 2'b00}) : tvec_base;
        mstatus_o = mstatus_q;
        mie_o     = mie_q;
    end

endmodule

// File: tb/tb_ysyx_040066_mcsr.sv
// tb_ysyx_040066_mcsr: directed checks of reads, writes, traps, mret and counters
module tb_ysyx_040066_mcsr;
  localparam int XLEN = 64;
  logic            clk = 1'b0;
  logic            rst;
  logic [11:0]     csr_rd_addr, csr_wr_addr;
  logic [XLEN-1:0] csr_rd_data, csr_wr_data, exc_tval, exc_pc, irq_pc, nxtpc, mstatus_o, mie_o;
  logic [XLEN-2:0] exc_cause;
  logic            csr_rd_err, csr_wr_en, csr_wr_err, exc_valid;
  logic            irq_msip, irq_mtip, irq_meip, mret, instret, jmp, irq_take;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  ysyx_040066_mcsr #(.XLEN(XLEN), .HARTID(7)) dut (
    .clk(clk), .rst(rst),
    .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data), .csr_rd_err(csr_rd_err),
    .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .csr_wr_err(csr_wr_err),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .exc_pc(exc_pc),
    .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip), .irq_pc(irq_pc),
    .mret(mret), .instret(instret),
    .jmp(jmp), .nxtpc(nxtpc), .irq_take(irq_take),
    .mstatus_o(mstatus_o), .mie_o(mie_o)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_rd_addr = a;
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [XLEN-1:0] d);
    csr_wr_en   = 1'b1;
    csr_wr_addr = a;
    csr_wr_data = d;
    step();
    csr_wr_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; csr_rd_addr = '0; csr_wr_en = 1'b0; csr_wr_addr = '0; csr_wr_data = '0;
    exc_valid = 1'b1; exc_cause = '0; exc_tval = '0; exc_pc = '0;
    irq_msip = 1'b0; irq_mtip = 1'b0; irq_meip = 1'b1; irq_pc = '0;
    mret = 1'b0; instret = 1'b0;
    #2;
    chk("rst_jmp", jmp, 1'b0);
    chk("rst_irq_take", irq_take, 1'b0);
    exc_valid = 1'b0; irq_meip = 1'b0;
    rd(12'h300); chk("rst_mstatus", csr_rd_data, 64'hA_0000_1800);
    chk("rst_mstatus_o", mstatus_o, 64'hA_0000_1800);
    rd(12'hF14); chk("mhartid", csr_rd_data, 64'd7);
    rd(12'h7C0); chk("unimpl_data", csr_rd_data, 64'd0);
    chk("unimpl_err", csr_rd_err, 1'b1);
    rd(12'h305); chk("rst_mtvec", csr_rd_data, 64'd0);
    step(); step();
    rst = 1'b0;
    rd(12'hB00); chk("mcycle_0", csr_rd_data, 64'd0);
    step();      chk("mcycle_1", csr_rd_data, 64'd1);
    wr(12'h305, 64'h1003); rd(12'h305); chk("mtvec_mode3", csr_rd_data, 64'h1000);
    wr(12'h305, 64'h8000_0001); rd(12'h305); chk("mtvec", csr_rd_data, 64'h8000_0001);
    wr(12'h304, 64'h888); chk("mie_o", mie_o, 64'h888);
    csr_rd_addr = 12'h300; csr_wr_en = 1'b1; csr_wr_addr = 12'h300;
    csr_wr_data = 64'hA_0000_1808; #1;
    chk("bypass", csr_rd_data, 64'hA_0000_1808);
    step(); csr_wr_en = 1'b0;
    chk("mstatus_wr", mstatus_o, 64'hA_0000_1808);
    csr_wr_en = 1'b1; csr_wr_addr = 12'h344; csr_wr_data = 64'hFFFF; #1;
    chk("mip_wr_err", csr_wr_err, 1'b0);
    step(); csr_wr_en = 1'b0;
    rd(12'h344); chk("mip_unchanged", csr_rd_data, 64'd0);
    csr_wr_en = 1'b1; csr_wr_addr = 12'h7C0; #1;
    chk("unimpl_wr_err", csr_wr_err, 1'b1);
    step(); csr_wr_en = 1'b0;
    wr(12'h341, 64'h203); rd(12'h341); chk("mepc_mask", csr_rd_data, 64'h200);
    irq_pc = 64'h444; irq_mtip = 1'b1; irq_meip = 1'b1; rd(12'h344);
    chk("mip_live", csr_rd_data, 64'h880);
    chk("irq_take", irq_take, 1'b1);
    chk("irq_jmp", jmp, 1'b1);
    chk("irq_nxtpc", nxtpc, 64'h8000_002C);
    step(); irq_mtip = 1'b0; irq_meip = 1'b0;
    rd(12'h342); chk("irq_mcause", csr_rd_data, 64'h8000_0000_0000_000B);
    rd(12'h300); chk("irq_mstatus", csr_rd_data, 64'hA_0000_1880);
    rd(12'h341); chk("irq_mepc", csr_rd_data, 64'h444);
    rd(12'h343); chk("irq_mtval", csr_rd_data, 64'd0);
    irq_meip = 1'b1; #1;
    chk("masked_irq_take", irq_take, 1'b0);
    chk("masked_jmp", jmp, 1'b0);
    wr(12'h300, 64'hA_0000_1888);
    exc_valid = 1'b1; exc_cause = 63'd2; exc_pc = 64'h100; exc_tval = 64'h55; #1;
    chk("exc_irq_take", irq_take, 1'b0);
    chk("exc_jmp", jmp, 1'b1);
    chk("exc_nxtpc", nxtpc, 64'h8000_0000);
    step(); exc_valid = 1'b0; irq_meip = 1'b0;
    rd(12'h341); chk("exc_mepc", csr_rd_data, 64'h100);
    rd(12'h342); chk("exc_mcause", csr_rd_data, 64'd2);
    rd(12'h343); chk("exc_mtval", csr_rd_data, 64'h55);
    rd(12'h300); chk("exc_mstatus", csr_rd_data, 64'hA_0000_1880);
    wr(12'h341, 64'h200);
    mret = 1'b1; csr_wr_en = 1'b1; csr_wr_addr = 12'h340; csr_wr_data = 64'h1234; #1;
    chk("mret_jmp", jmp, 1'b1);
    chk("mret_nxtpc", nxtpc, 64'h200);
    step(); mret = 1'b0; csr_wr_en = 1'b0;
    rd(12'h300); chk("mret_mstatus", csr_rd_data, 64'hA_0000_0088);
    rd(12'h340); chk("mret_drops_wr", csr_rd_data, 64'd0);
    irq_msip = 1'b1; irq_mtip = 1'b1; #1;
    chk("msi_take", irq_take, 1'b1);
    chk("msi_over_mti", nxtpc, 64'h8000_000C);
    irq_msip = 1'b0; irq_mtip = 1'b0; #1;
    chk("irq_cleared", irq_take, 1'b0);
    wr(12'hB00, '1); rd(12'hB00); chk("mcycle_override", csr_rd_data, 64'hFFFF_FFFF_FFFF_FFFF);
    step(); chk("mcycle_wrap", csr_rd_data, 64'd0);
    instret = 1'b1; step(); step(); step(); instret = 1'b0;
    rd(12'hB02); chk("minstret_3", csr_rd_data, 64'd3);
    rst = 1'b1; #1;
    rd(12'h305); chk("async_rst_mtvec", csr_rd_data, 64'd0);
    rd(12'hB02); chk("async_rst_minstret", csr_rd_data, 64'd0);
    chk("async_rst_mie_o", mie_o, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
